hazard_stall_controller: RTL and testbench
==========================================

HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 SHALL have port Clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port Rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports ID_RegRs and ID_RegRt, input, 5 each, source registers of the instruction in ID.
REQ-004 SHALL have ports ID_UsesRs and ID_UsesRt, input, 1 each, high when the ID instruction actually reads that source.
REQ-005 SHALL have port ID_Branch, input, 1, high when the ID instruction is a branch or jr resolved in ID.
REQ-006 SHALL have port BranchTaken, input, 1, ID branch resolved taken this cycle.
REQ-007 SHALL have ports EX_Rd, EX_RegWrite and EX_MemRead, input, 5/1/1, destination and control of the EX instruction.
REQ-008 SHALL have ports MEM_Rd, MEM_RegWrite and MEM_MemRead, input, 5/1/1, destination and control of the MEM instruction.
REQ-009 SHALL have port ClearCounters, input, 1, synchronous clear of the performance counters.
REQ-010 SHALL have ports PCWrite and IFID_Write, output, 1 each, low to freeze the PC and the IF/ID register.
REQ-011 SHALL have port IDEX_Bubble, output, 1, high to zero ID/EX control (insert nop).
REQ-012 SHALL have port IFID_Flush, output, 1, high to zero IF/ID on a taken branch.
REQ-013 SHALL have ports StallCycles and FlushCount, output, 16 each, saturating performance counters.

Function
REQ-014 SHALL define match(X) as X != 0 and ((ID_UsesRs and ID_RegRs == X) or (ID_UsesRt and ID_RegRt == X)).
REQ-015 SHALL detect a 2-cycle hazard when EX_MemRead, match(EX_Rd) and ID_Branch are all true.
REQ-016 SHALL detect a 1-cycle hazard when EX_MemRead and match(EX_Rd) with ID_Branch low; or EX_RegWrite, not EX_MemRead, match(EX_Rd) and ID_Branch; or MEM_MemRead, match(MEM_Rd) and ID_Branch.
REQ-017 SHALL define stall = (state == HOLD) or any hazard detected; stall SHALL be combinational with zero-cycle latency.
REQ-018 SHALL, when stall is high, drive PCWrite=0, IFID_Write=0 and IDEX_Bubble=1; otherwise PCWrite=1, IFID_Write=1 and IDEX_Bubble=0.
REQ-019 SHALL drive IFID_Flush = BranchTaken and not stall; a taken branch during a stall SHALL be ignored.
REQ-020 SHALL implement states IDLE and HOLD with a 2-bit remaining-count register Rem.
REQ-021 SHALL, in IDLE on a 2-cycle hazard, go to HOLD with Rem=1 at the next edge; on a 1-cycle hazard or no hazard, remain in IDLE.
REQ-022 SHALL, in HOLD, decrement Rem at each edge and return to IDLE when Rem reaches 0; hazards detected in HOLD SHALL NOT extend or restart the count.
REQ-023 SHALL increment StallCycles at each edge where stall=1, saturating at 0xFFFF.
REQ-024 SHALL increment FlushCount at each edge where IFID_Flush=1, saturating at 0xFFFF.
REQ-025 SHALL give ClearCounters priority over increments: the counters read 0 after that edge.
REQ-026 SHALL never treat register 0 as a hazard source, regardless of write flags.

Reset
REQ-027 SHALL, on Rst at a clock edge, set state=IDLE, Rem=0, StallCycles=0 and FlushCount=0.
REQ-028 SHALL, when Rst is asserted mid-HOLD, abandon the HOLD; the outputs then follow only the combinational detection of REQ-017.
REQ-029 SHALL leave counters and state undisturbed by ClearCounters apart from the counters themselves.

Structure
REQ-030 SHALL place the state encoding (IDLE, HOLD) and the counter width constant (16) in the shared package hazard_pkg.
REQ-031 SHALL instantiate sub-module sat_counter16 (enable, clear, saturate) twice, once for StallCycles and once for FlushCount.
REQ-032 SHALL keep all detection logic combinational and all state in a single clocked process.

Verification
REQ-033 SHALL cover load-use with EX_MemRead=1, EX_Rd=8 and ID_RegRs=8 with ID_UsesRs=1 and ID_Branch=0: exactly 1 cycle of PCWrite=0 and IDEX_Bubble=1, and StallCycles +1.
REQ-034 SHALL cover load-to-branch with EX_MemRead=1, EX_Rd=9, ID_RegRt=9 and ID_Branch=1, with inputs then cleared: stall for 2 consecutive cycles, with HOLD on the second.
REQ-035 SHALL cover EX_Rd=0 with EX_MemRead=1 and ID_RegRs=0: no stall.
REQ-036 SHALL cover BranchTaken=1 with no hazard: IFID_Flush=1 and FlushCount +1; BranchTaken=1 together with a 1-cycle hazard: IFID_Flush=0.
REQ-037 SHALL cover Rst asserted in the cycle after a 2-cycle hazard, with inputs cleared: stall=0 after the edge and both counters 0.
REQ-038 SHALL cover 65540 forced stall cycles: StallCycles holds at 0xFFFF, then ClearCounters=1 gives 0 at the next edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// +----------------------------------------------------------------------+
// | hazard_pkg: shared state encoding, counter width and operand matcher |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package hazard_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // Register 0 is hardwired to zero, so it can never carry a dependency.
   function automatic logic reg_match(
      input logic [4:0] x,
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic       uses_rs,
      input logic       uses_rt
   );
      return (x != 5'd0) && ((uses_rs && (rs == x)) || (uses_rt && (rt == x)));
   endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stall_controller_sat_counter16.sv
// +----------------------------------------------------------------------+
// | sat_counter16: saturating event counter with priority clear          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sat_counter16
   import hazard_pkg::*;
(
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Clear_i,
   input  logic             Enable_i,
   output logic [CNT_W-1:0] Count_o
);

   logic [CNT_W-1:0] count_q;

   always_ff @(posedge Clk) begin
      if (Rst || Clear_i) begin
         count_q <= '0;
      end else if (Enable_i && (count_q != '1)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign Count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/hazard_stall_controller.sv
// +----------------------------------------------------------------------+
// | hazard_stall_controller: load-use / branch stall and IF/ID flush     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module hazard_stall_controller
   import hazard_pkg::*;
(
   input  logic             Clk,
   input  logic             Rst,
   input  logic [4:0]       ID_RegRs,
   input  logic [4:0]       ID_RegRt,
   input  logic             ID_UsesRs,
   input  logic             ID_UsesRt,
   input  logic             ID_Branch,
   input  logic             BranchTaken,
   input  logic [4:0]       EX_Rd,
   input  logic             EX_RegWrite,
   input  logic             EX_MemRead,
   input  logic [4:0]       MEM_Rd,
   input  logic             MEM_RegWrite,
   input  logic             MEM_MemRead,
   input  logic             ClearCounters,
   output logic             PCWrite,
   output logic             IFID_Write,
   output logic             IDEX_Bubble,
   output logic             IFID_Flush,
   output logic [CNT_W-1:0] StallCycles,
   output logic [CNT_W-1:0] FlushCount
);

   state_e     state_q, state_d;
   logic [1:0] rem_q, rem_d;

   logic match_ex, match_mem;
   logic haz_two, haz_one, stall;
   logic mem_regwrite_unused;

   // MEM-stage ALU results are forwarded, so only MEM loads feed a hazard.
   assign mem_regwrite_unused = MEM_RegWrite;

   assign match_ex  = reg_match(EX_Rd,  ID_RegRs, ID_RegRt, ID_UsesRs, ID_UsesRt);
   assign match_mem = reg_match(MEM_Rd, ID_RegRs, ID_RegRt, ID_UsesRs, ID_UsesRt);

   assign haz_two = EX_MemRead && match_ex && ID_Branch;
   assign haz_one = (EX_MemRead && match_ex && !ID_Branch)
                 || (EX_RegWrite && !EX_MemRead && match_ex && ID_Branch)
                 || (MEM_MemRead && match_mem && ID_Branch);

   assign stall       = (state_q == ST_HOLD) || haz_one || haz_two;
   assign PCWrite     = !stall;
   assign IFID_Write  = !stall;
   assign IDEX_Bubble = stall;
   assign IFID_Flush  = BranchTaken && !stall;

   // HOLD covers only the second cycle of a load-to-branch stall; new hazards
   // seen while holding are not allowed to restart the count.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      case (state_q)
         ST_IDLE: begin
            if (haz_two) begin
               state_d = ST_HOLD;
               rem_d   = 2'd1;
            end
         end
         ST_HOLD: begin
            if (rem_q <= 2'd1) begin
               state_d = ST_IDLE;
               rem_d   = 2'd0;
            end else begin
               rem_d = rem_q - 2'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            rem_d   = 2'd0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_IDLE;
         rem_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
      end
   end

   sat_counter16 u_stall_cnt (
      .Clk      (Clk),
      .Rst      (Rst),
      .Clear_i  (ClearCounters),
      .Enable_i (stall),
      .Count_o  (StallCycles)
   );

   sat_counter16 u_flush_cnt (
      .Clk      (Clk),
      .Rst      (Rst),
      .Clear_i  (ClearCounters),
      .Enable_i (IFID_Flush),
      .Count_o  (FlushCount)
   );

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_controller.sv
// +----------------------------------------------------------------------+
// | tb_hazard_stall_controller: directed vectors with fixed expectations |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_hazard_stall_controller;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [4:0]  ID_RegRs, ID_RegRt, EX_Rd, MEM_Rd;
   logic        ID_UsesRs, ID_UsesRt, ID_Branch, BranchTaken;
   logic        EX_RegWrite, EX_MemRead, MEM_RegWrite, MEM_MemRead;
   logic        ClearCounters;
   logic        PCWrite, IFID_Write, IDEX_Bubble, IFID_Flush;
   logic [15:0] StallCycles, FlushCount;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   hazard_stall_controller dut (
      .Clk           (Clk),
      .Rst           (Rst),
      .ID_RegRs      (ID_RegRs),
      .ID_RegRt      (ID_RegRt),
      .ID_UsesRs     (ID_UsesRs),
      .ID_UsesRt     (ID_UsesRt),
      .ID_Branch     (ID_Branch),
      .BranchTaken   (BranchTaken),
      .EX_Rd         (EX_Rd),
      .EX_RegWrite   (EX_RegWrite),
      .EX_MemRead    (EX_MemRead),
      .MEM_Rd        (MEM_Rd),
      .MEM_RegWrite  (MEM_RegWrite),
      .MEM_MemRead   (MEM_MemRead),
      .ClearCounters (ClearCounters),
      .PCWrite       (PCWrite),
      .IFID_Write    (IFID_Write),
      .IDEX_Bubble   (IDEX_Bubble),
      .IFID_Flush    (IFID_Flush),
      .StallCycles   (StallCycles),
      .FlushCount    (FlushCount)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic clr_in();
      ID_RegRs = 5'd0; ID_RegRt = 5'd0; ID_UsesRs = 1'b0; ID_UsesRt = 1'b0;
      ID_Branch = 1'b0; BranchTaken = 1'b0;
      EX_Rd = 5'd0; EX_RegWrite = 1'b0; EX_MemRead = 1'b0;
      MEM_Rd = 5'd0; MEM_RegWrite = 1'b0; MEM_MemRead = 1'b0;
      ClearCounters = 1'b0;
   endtask

   // Advance one edge, then settle before anything is sampled or driven.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Checks the three stall-driven outputs together against one expected stall.
   task automatic chk_stall(input string tag, input logic exp_stall);
      #1;
      chk({tag, ".pcw"},  32'(PCWrite),     32'(!exp_stall));
      chk({tag, ".ifw"},  32'(IFID_Write),  32'(!exp_stall));
      chk({tag, ".bub"},  32'(IDEX_Bubble), 32'(exp_stall));
   endtask

   task automatic load_use();
      EX_MemRead = 1'b1; EX_Rd = 5'd8; ID_RegRs = 5'd8; ID_UsesRs = 1'b1;
   endtask

   task automatic load_branch();
      EX_MemRead = 1'b1; EX_Rd = 5'd9; ID_RegRt = 5'd9; ID_UsesRt = 1'b1; ID_Branch = 1'b1;
   endtask

   initial begin
      clr_in();
      Rst = 1'b1;
      tick(); tick();
      Rst = 1'b0;
      chk_stall("reset", 1'b0);
      chk("reset.flush", 32'(IFID_Flush), 32'd0);
      chk("reset.sc", 32'(StallCycles), 32'd0);
      chk("reset.fc", 32'(FlushCount), 32'd0);

      // Load-use: exactly one stall cycle.
      load_use();
      chk_stall("lu.det", 1'b1);
      tick(); clr_in();
      chk_stall("lu.after", 1'b0);
      chk("lu.sc", 32'(StallCycles), 32'd1);

      // Load-to-branch: detection cycle plus one HOLD cycle.
      load_branch();
      chk_stall("lb.det", 1'b1);
      tick(); clr_in();
      chk_stall("lb.hold", 1'b1);
      tick();
      chk_stall("lb.done", 1'b0);
      chk("lb.sc", 32'(StallCycles), 32'd3);

      // A second load-to-branch seen during HOLD must not restart it.
      load_branch();
      tick();
      chk_stall("rehz.hold", 1'b1);
      tick(); clr_in();
      chk_stall("rehz.done", 1'b0);
      chk("rehz.sc", 32'(StallCycles), 32'd5);

      // Register 0 never creates a hazard.
      EX_MemRead = 1'b1; EX_Rd = 5'd0; ID_RegRs = 5'd0; ID_UsesRs = 1'b1;
      chk_stall("r0.load", 1'b0);
      EX_RegWrite = 1'b1; EX_MemRead = 1'b0; ID_Branch = 1'b1;
      MEM_MemRead = 1'b1; MEM_Rd = 5'd0;
      chk_stall("r0.branch", 1'b0);
      clr_in();

      // Source not actually read.
      EX_MemRead = 1'b1; EX_Rd = 5'd8; ID_RegRs = 5'd8; ID_UsesRs = 1'b0;
      chk_stall("nouse", 1'b0);
      clr_in();

      // ALU result in EX feeding a branch: one cycle only.
      EX_RegWrite = 1'b1; EX_Rd = 5'd5; ID_RegRs = 5'd5; ID_UsesRs = 1'b1; ID_Branch = 1'b1;
      chk_stall("exalu.det", 1'b1);
      tick(); clr_in();
      chk_stall("exalu.after", 1'b0);

      // Load in MEM feeding a branch: one cycle only.
      MEM_MemRead = 1'b1; MEM_Rd = 5'd7; ID_RegRt = 5'd7; ID_UsesRt = 1'b1; ID_Branch = 1'b1;
      chk_stall("memld.det", 1'b1);
      tick(); clr_in();
      chk_stall("memld.after", 1'b0);
      chk("memld.sc", 32'(StallCycles), 32'd7);

      // ALU result in MEM is forwardable: no stall.
      MEM_RegWrite = 1'b1; MEM_Rd = 5'd7; ID_RegRt = 5'd7; ID_UsesRt = 1'b1; ID_Branch = 1'b1;
      chk_stall("memalu", 1'b0);
      clr_in();

      // Taken branch, no hazard.
      BranchTaken = 1'b1; ID_Branch = 1'b1;
      #1 chk("bt.flush", 32'(IFID_Flush), 32'd1);
      tick(); clr_in();
      chk("bt.fc", 32'(FlushCount), 32'd1);

      // Taken branch during a stall is ignored.
      load_use(); BranchTaken = 1'b1;
      #1 chk("btst.flush", 32'(IFID_Flush), 32'd0);
      tick(); clr_in();
      chk("btst.fc", 32'(FlushCount), 32'd1);
      chk("btst.sc", 32'(StallCycles), 32'd8);

      // Clear on the HOLD-entry edge leaves the FSM alone.
      load_branch(); ClearCounters = 1'b1;
      tick(); clr_in();
      chk("clr.sc", 32'(StallCycles), 32'd0);
      chk("clr.fc", 32'(FlushCount), 32'd0);
      chk_stall("clr.hold", 1'b1);
      tick();
      chk("clr.sc2", 32'(StallCycles), 32'd1);

      // Reset in the HOLD cycle abandons the hold.
      load_branch();
      tick(); clr_in();
      Rst = 1'b1;
      chk_stall("rst.hold", 1'b1);
      tick();
      Rst = 1'b0;
      chk_stall("rst.after", 1'b0);
      chk("rst.sc", 32'(StallCycles), 32'd0);
      chk("rst.fc", 32'(FlushCount), 32'd0);

      // Saturation after 65540 stall cycles, then clear.
      load_use();
      for (int i = 0; i < 65540; i++) tick();
      chk("sat.sc", 32'(StallCycles), 32'hFFFF);
      tick();
      chk("sat.hold", 32'(StallCycles), 32'hFFFF);
      ClearCounters = 1'b1;
      tick();
      chk("sat.clr", 32'(StallCycles), 32'd0);
      ClearCounters = 1'b0;
      tick();
      chk("sat.resume", 32'(StallCycles), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
